// File: rtl/sign_extend.sv
// Immediate-extension unit for the decode stage: widens an instruction immediate
// to a datapath operand, with a combinational result and a registered copy.
module sign_extend #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out,
    output logic [OUT_WIDTH-1:0] out_q,
    output logic                 out_valid
);

    localparam int EXT_WIDTH = OUT_WIDTH - IN_WIDTH;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // The branch shift needs two spare bits above the immediate.
    generate
        if (OUT_WIDTH < IN_WIDTH + 2) begin : g_width_check
            $error("sign_extend: OUT_WIDTH must be at least IN_WIDTH + 2");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] w_sext;
    logic [OUT_WIDTH-1:0] w_zext;
    logic [OUT_WIDTH-1:0] w_upper;
    logic [OUT_WIDTH-1:0] w_branch;
    logic [OUT_WIDTH-1:0] w_out;

    assign w_sext   = {{EXT_WIDTH{in[IN_WIDTH-1]}}, in};
    assign w_zext   = {{EXT_WIDTH{1'b0}}, in};
    assign w_upper  = {in, {EXT_WIDTH{1'b0}}};
    assign w_branch = {w_sext[OUT_WIDTH-3:0], 2'b00};

    always_comb begin
        w_out = w_sext;
        case (mode)
            MODE_SIGN:   w_out = w_sext;
            MODE_ZERO:   w_out = w_zext;
            MODE_UPPER:  w_out = w_upper;
            MODE_BRANCH: w_out = w_branch;
            default:     w_out = w_sext;
        endcase
    end

    assign out = w_out;

    logic [OUT_WIDTH-1:0] r_out_q;
    logic                 r_out_valid;

    // Data holds when the input is not qualified; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_q <= w_out;
            end
        end
    end

    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sign_extend.sv
// Directed self-checking bench for sign_extend: combinational modes, registered
// path through a scoreboard queue, asynchronous reset and back-to-back capture.
module tb_sign_extend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] q;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_q = 32'h0;

    sign_extend #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .mode     (mode),
        .in_valid (in_valid),
        .out      (out),
        .out_q    (out_q),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Arithmetic reference model, independent of bit slicing.
    function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
        int s;
        s = int'($signed(v));
        case (m)
            2'b00:   return 32'(s);
            2'b01:   return 32'(int'(v));
            2'b10:   return 32'(int'(v) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic comb(input string tag, input logic [15:0] v, input logic [1:0] m,
                        input logic [31:0] exp_v);
        in   = v;
        mode = m;
        #1;
        chk(tag, out, exp_v);
    endtask

    // Drive one cycle on the falling edge, score the expected capture, compare after the edge.
    task automatic step(input string tag, input logic v, input logic [15:0] d, input logic [1:0] m);
        exp_t e;
        @(negedge clk);
        in       = d;
        mode     = m;
        in_valid = v;
        if (v) model_q = ref_ext(d, m);
        sb.push_back('{v: v, q: model_q});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q"}, out_q, e.q);
            chk({tag, "_valid"}, {31'h0, out_valid}, {31'h0, e.v});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in       = 16'h0;
        mode     = 2'b00;
        in_valid = 1'b0;
        #2;
        chk("rst_q", out_q, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);

        comb("sign_0",     16'h0000, 2'b00, 32'h00000000);
        comb("sign_5",     16'h0005, 2'b00, 32'h00000005);
        comb("sign_3018",  16'h3018, 2'b00, 32'h00003018);
        comb("sign_m123",  16'hFF85, 2'b00, 32'hFFFFFF85);
        comb("sign_m345",  16'hFEA7, 2'b00, 32'hFFFFFEA7);
        comb("sign_m1",    16'hFFFF, 2'b00, 32'hFFFFFFFF);
        comb("sign_3",     16'h0003, 2'b00, 32'h00000003);
        comb("zero_ff85",  16'hFF85, 2'b01, 32'h0000FF85);
        comb("upper_ff85", 16'hFF85, 2'b10, 32'hFF850000);
        comb("br_ff85",    16'hFF85, 2'b11, 32'hFFFFFE14);
        comb("upper_1234", 16'h1234, 2'b10, 32'h12340000);
        comb("br_1234",    16'h1234, 2'b11, 32'h000048D0);
        comb("sign_8000",  16'h8000, 2'b00, 32'hFFFF8000);
        comb("sign_7fff",  16'h7FFF, 2'b00, 32'h00007FFF);
        comb("br_8000",    16'h8000, 2'b11, 32'hFFFE0000);
        comb("zero_ffff",  16'hFFFF, 2'b01, 32'h0000FFFF);

        @(negedge clk);
        rst_n = 1'b1;

        step("reg_m1",   1'b1, 16'hFFFF, 2'b00);
        step("reg_hold", 1'b0, 16'h1234, 2'b00);

        // Reset between edges with a valid input in flight.
        @(negedge clk);
        in       = 16'hFF85;
        mode     = 2'b00;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_q", out_q, 32'h0);
        chk("arst_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_comb", out, 32'hFFFFFF85);
        model_q = 32'h0;
        @(posedge clk);
        #1;
        chk("arst_hold_q", out_q, 32'h0);
        chk("arst_hold_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step("post_rst_3", 1'b1, 16'h0003, 2'b00);
        step("b2b_5",      1'b1, 16'h0005, 2'b00);
        step("b2b_m123",   1'b1, 16'hFF85, 2'b00);
        step("b2b_3",      1'b1, 16'h0003, 2'b00);
        step("reg_zero",   1'b1, 16'hFF85, 2'b01);
        step("reg_upper",  1'b1, 16'h1234, 2'b10);
        step("reg_branch", 1'b1, 16'h8000, 2'b11);
        step("reg_idle",   1'b0, 16'h7FFF, 2'b00);
        step("reg_7fff",   1'b1, 16'h7FFF, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
Name: sign_extend

Overview:
- Immediate-extension unit for the MIPS datapath decode stage; widens a 16-bit instruction immediate to a 32-bit operand.
- Provides a combinational result for same-cycle use and a registered copy for the pipeline register boundary.
- Supports sign-extend (default), zero-extend, upper-immediate placement and branch-offset (sign-extend then shift left 2).

Parameters:
- IN_WIDTH, 16, immediate width.
- OUT_WIDTH, 32, extended result width; must satisfy OUT_WIDTH >= IN_WIDTH + 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- in  input  IN_WIDTH  immediate field of the instruction.
- mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
- in_valid  input  1  qualifies in/mode for the registered path.
- out  output  OUT_WIDTH  combinational extended result.
- out_q  output  OUT_WIDTH  registered extended result.
- out_valid  output  1  out_q holds a result captured from a valid input.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- The combinational path "out" is purely a function of in and mode, with zero latency and no dependence on clk or rst_n.
- mode 00, sign:
  - out[IN_WIDTH-1:0] = in.
  - out[OUT_WIDTH-1:IN_WIDTH] = replicated in[IN_WIDTH-1].
- mode 01, zero:
  - out[IN_WIDTH-1:0] = in.
  - Upper bits are 0.
- mode 10, upper:
  - out[OUT_WIDTH-1:OUT_WIDTH-IN_WIDTH] = in.
  - Lower bits are 0.
  - With the defaults this gives {in, 16'h0000}.
- mode 11, branch:
  - out = (sign-extended in) << 2.
  - Bits [1:0] are 0.
  - Bits shifted past the MSB are discarded.
- Registered path:
  - On a rising clk edge with in_valid=1: out_q <= value of out at that edge, and out_valid <= 1.
  - On a rising clk edge with in_valid=0: out_q holds its value, and out_valid <= 0.
  - Latency from input to out_q is 1 cycle.
  - No back-pressure; a new valid input is accepted every cycle.
- Reset:
  - While rst_n=0: out_q = 0 and out_valid = 0 immediately, asynchronously.
  - Release is synchronous to clk; the first capture happens on the first rising edge with rst_n=1.
  - Reset asserted mid-stream discards any result in flight.
  - out keeps tracking its inputs during reset.
- Boundaries:
  - in = 0x8000 (most negative) sign-extends to 0xFFFF8000.
  - in = 0x7FFF (most positive) gives 0x00007FFF.
  - in = 0xFFFF gives 0xFFFFFFFF in sign mode and 0x0000FFFF in zero mode.
- No X propagation from unused modes: all four encodings are defined.

Test Plan:
- Sign mode, combinational, checking out after each change:
  - in = 0 -> 0x00000000.
  - in = 5 -> 0x00000005.
  - in = 12312 (0x3018) -> 0x00003018.
  - in = -123 (0xFF85) -> 0xFFFFFF85.
  - in = -345 (0xFEA7) -> 0xFFFFFEA7.
  - in = -1 -> 0xFFFFFFFF.
  - in = 3 -> 0x00000003.
- Mode sweep with in = 0xFF85:
  - mode 01 -> 0x0000FF85.
  - mode 10 -> 0xFF850000.
  - mode 11 -> 0xFFFFFE14.
  - Repeat with in = 0x1234: mode 10 -> 0x12340000, mode 11 -> 0x000048D0.
- Extremes in sign mode:
  - in = 0x8000 -> 0xFFFF8000.
  - in = 0x7FFF -> 0x00007FFF.
  - Branch mode with in = 0x8000 -> 0xFFFE0000.
- Registered path:
  - Drive in_valid=1 with in = -1, mode 00.
  - One edge later: out_q = 0xFFFFFFFF and out_valid = 1.
  - Deassert in_valid and change in: out_q holds and out_valid drops to 0 on the next edge.
- Reset: assert rst_n=0 between clock edges while out_q is nonzero.
  - out_q = 0 and out_valid = 0 immediately, without waiting for a clock edge.
  - The combinational out still equals the extension of the current in.
  - After release, the first valid capture appears exactly one edge later.
- Back-to-back: apply 5, -123, 3 with in_valid=1 on consecutive cycles.
  - out_q sequence is 0x00000005, 0xFFFFFF85, 0x00000003 on consecutive edges.
  - out_valid stays 1 throughout.
